// File: rtl/reg_file_param_pkg.sv
// Shared constants and types for the parametrised general-purpose register file.
package reg_file_param_pkg;

    // Default geometry: 32 words of 32 bits.
    localparam int unsigned RF_DEF_DATA_WIDTH = 32;
    localparam int unsigned RF_DEF_ADDR_WIDTH = 5;

    // Address of the optional hardwired-zero entry.
    localparam int unsigned RF_ZERO_ADDR = 0;

    // Word type at the default data width.
    typedef logic [RF_DEF_DATA_WIDTH-1:0] rf_word_t;

    // True when a read address must be forced to the hardwired-zero entry.
    function automatic logic rf_is_zero_entry(input logic zero_reg, input int unsigned addr);
        return zero_reg && (addr == RF_ZERO_ADDR);
    endfunction

endpackage

// File: rtl/reg_word_pp.sv
// One register-file word: load-enabled register with an async active-low
// reset that presets every bit from a pattern parameter.
module reg_word_pp
    import reg_file_param_pkg::*;
#(
    parameter int unsigned                    WIDTH   = RF_DEF_DATA_WIDTH,
    parameter logic [WIDTH-1:0]               PATTERN = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Next-state: take new data only when this word is selected.
    always_comb begin
        word_d = word_q;
        if (LOAD) begin
            word_d = D;
        end else begin
            word_d = word_q;
        end
    end

    // Word storage; reset presets the pattern regardless of the clock.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            word_q <= PATTERN;
        end else begin
            word_q <= word_d;
        end
    end

    assign Q = word_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered read ports,
// optional hardwired-zero entry 0 and optional write-to-read bypass.
module reg_file_param
    import reg_file_param_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = RF_DEF_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH    = RF_DEF_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PATTERN = '0,
    parameter bit                    ZERO_REG      = 1'b1,
    parameter bit                    BYPASS        = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  RD_VALID
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_s [DEPTH];

    logic [DATA_WIDTH-1:0] data_r1_d;
    logic [DATA_WIDTH-1:0] data_r2_d;
    logic [DATA_WIDTH-1:0] data_r1_q;
    logic [DATA_WIDTH-1:0] data_r2_q;
    logic                  rd_valid_q;

    // Storage array. Each word's load enable is one output of the
    // WRITE-gated one-hot decode of ADDR_W, so at most one word loads.
    // A hardwired-zero entry 0 has no storage at all, which is what
    // drops writes to it.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (ZERO_REG && (i == RF_ZERO_ADDR)) begin : g_zero
            assign mem_s[i] = '0;
        end else begin : g_reg
            logic load_s;
            assign load_s = WRITE && (ADDR_W == ADDR_WIDTH'(i));
            reg_word_pp #(
                .WIDTH   (DATA_WIDTH),
                .PATTERN (RESET_PATTERN)
            ) u_word (
                .CLK   (CLK),
                .RESET (RESET),
                .LOAD  (load_s),
                .D     (DATA_W),
                .Q     (mem_s[i])
            );
        end
    end

    // Write data forwards to a read of the same address in the same cycle,
    // except into the hardwired-zero entry, which must keep reading 0.
    function automatic logic bypass_hit(input logic [ADDR_WIDTH-1:0] rd_addr);
        return BYPASS && WRITE && (rd_addr == ADDR_W)
               && !rf_is_zero_entry(ZERO_REG, int'(rd_addr));
    endfunction

    // Read select: array mux per port, then the bypass override.
    always_comb begin
        data_r1_d = mem_s[ADDR_R1];
        data_r2_d = mem_s[ADDR_R2];
        if (bypass_hit(ADDR_R1)) begin
            data_r1_d = DATA_W;
        end else begin
            data_r1_d = mem_s[ADDR_R1];
        end
        if (bypass_hit(ADDR_R2)) begin
            data_r2_d = DATA_W;
        end else begin
            data_r2_d = mem_s[ADDR_R2];
        end
    end

    // Read output registers; RD_VALID pulses for one cycle per READ edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            data_r1_q  <= {DATA_WIDTH{1'b0}};
            data_r2_q  <= {DATA_WIDTH{1'b0}};
            rd_valid_q <= 1'b0;
        end else if (READ) begin
            data_r1_q  <= data_r1_d;
            data_r2_q  <= data_r2_d;
            rd_valid_q <= 1'b1;
        end else begin
            data_r1_q  <= data_r1_q;
            data_r2_q  <= data_r2_q;
            rd_valid_q <= 1'b0;
        end
    end

    assign DATA_R1  = data_r1_q;
    assign DATA_R2  = data_r2_q;
    assign RD_VALID = rd_valid_q;

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised multi-entry register file; successor to the fixed 32-bit preset-pattern register.
- Provides 2^ADDR_WIDTH words of DATA_WIDTH bits, one write port and two registered read ports.
- Supports an optional hardwired-zero entry 0, a per-word reset pattern, and selectable write-to-read bypass.
- Sits in the datapath as the general-purpose register bank between decode and ALU.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 5, address bits; depth = 2^ADDR_WIDTH
RESET_PATTERN, 0, DATA_WIDTH-bit value loaded into every entry on reset
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to a read of the same address

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
READ  input  1  read strobe; capture both read ports this edge
WRITE  input  1  write strobe; commit DATA_W this edge
ADDR_R1  input  ADDR_WIDTH  read port 1 address
ADDR_R2  input  ADDR_WIDTH  read port 2 address
ADDR_W  input  ADDR_WIDTH  write address
DATA_W  input  DATA_WIDTH  write data
DATA_R1  output  DATA_WIDTH  registered read data, port 1
DATA_R2  output  DATA_WIDTH  registered read data, port 2
RD_VALID  output  1  one-cycle pulse: DATA_R1/R2 updated on the previous edge

Behaviour:
- Reset: RESET=0 acts immediately, independent of CLK. Every entry = RESET_PATTERN; entry 0 = 0 when ZERO_REG=1. DATA_R1 = 0, DATA_R2 = 0, RD_VALID = 0. The state holds while RESET=0, and strobes are ignored.
- Reset deassertion: the first rising edge with RESET=1 operates normally.
- Write: at a rising edge with WRITE=1, entry[ADDR_W] <= DATA_W. All other entries hold.
  - ZERO_REG=1 and ADDR_W=0: write dropped; entry 0 stays 0.
  - Write enables come from a one-hot decode of ADDR_W gated by WRITE. Exactly one entry is enabled, or none.
- Read: at a rising edge with READ=1, DATA_R1 <= entry[ADDR_R1] and DATA_R2 <= entry[ADDR_R2]. RD_VALID <= 1.
  - READ=0: DATA_R1/R2 hold their last values; RD_VALID <= 0.
  - Latency is 1 clock, address to data.
- Simultaneous READ and WRITE, ADDR_Rx == ADDR_W:
  - BYPASS=1: DATA_Rx <= DATA_W (write-first).
  - BYPASS=0: DATA_Rx <= previous entry contents (read-first).
  - Either way, the entry itself takes DATA_W.
- Bypass to entry 0: suppressed when ZERO_REG=1. Reading address 0 always returns 0.
- Both read ports at the same address: both return the identical value.
- Address range: all addresses 0..2^ADDR_WIDTH-1 are valid; no out-of-range case exists.
- Width: no sign extension or truncation; data is passed bit-exact.
- Reset during a READ/WRITE edge: reset wins; that edge's write and read are discarded.

Decomposition:
- Shared package:
  - default DATA_WIDTH/ADDR_WIDTH constants
  - RF_ZERO_ADDR constant (0)
  - word type sized by DATA_WIDTH
- Sub-module reg_word_pp:
  - one DATA_WIDTH register with LOAD enable, async active-low RESET, and per-bit preset from a pattern parameter
  - instantiated 2^ADDR_WIDTH times, or with tie-off for entry 0 when ZERO_REG=1
- Write decode: a parametrised ADDR_WIDTH-to-2^ADDR_WIDTH one-hot decoder gated by WRITE.
- Read select: a parametrised mux per port, followed by the bypass compare and the output register.

Test Plan:
- Reset with RESET_PATTERN=32'hDEAD_BEEF, ZERO_REG=1, then READ ADDR_R1=0, ADDR_R2=7:
  - DATA_R1 = 0, DATA_R2 = 32'hDEADBEEF
  - RD_VALID = 1 exactly one cycle later
- WRITE ADDR_W=5 DATA_W=32'h1234_5678, next cycle READ ADDR_R1=5 ADDR_R2=5:
  - both outputs = 32'h12345678
  - other entries unchanged (spot-check 4, 6)
- Same-edge WRITE ADDR_W=9 DATA_W=32'hA5A5_A5A5 and READ ADDR_R1=9, entry 9 previously 32'h0000_0011:
  - BYPASS=1 build: DATA_R1 = 32'hA5A5A5A5
  - BYPASS=0 build: DATA_R1 = 32'h00000011
  - subsequent read = 32'hA5A5A5A5 in both builds
- WRITE ADDR_W=0 DATA_W=32'hFFFF_FFFF with ZERO_REG=1, including same-edge READ of 0:
  - DATA_R1 = 0 on that read and on a later read
- READ=0 for 3 cycles after a read of 32'h1234_5678:
  - DATA_R1 holds 32'h12345678
  - RD_VALID = 0
- Assert RESET=0 mid-cycle, between edges, after writes to entries 1..31:
  - DATA_R1/R2 and RD_VALID clear immediately
  - after release, a read of any entry returns RESET_PATTERN
